umem_arbiter: RTL

Two-requester arbiter and sequencer for the single-ported unified memory. It accepts line-fill requests from the instruction side and line read/write (fill or evict) requests from the data side, grants one at a time, and drives the memory strobes until the memory's `rdy`. It returns read data through a one-cycle `done` handshake. It sits between the cache controller and the unified memory and replaces the controller's direct strobe muxing.

---
 rtl/umem_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/umem_arbiter.sv
// umem_arbiter: two-requester arbiter and sequencer for the single-ported
// unified memory. The instruction side issues line fills. The data side issues
// line fills or line write-backs. One operation is granted at a time. The block
// holds the memory strobes until the memory pulses mem_rdy, then returns a
// one-cycle done pulse together with a registered read line.
//
// Build option:
//   ARB_RR_EN  defined   -> round-robin tie-break using a 1-bit last-served
//                           pointer (the first tie after reset goes to D)
//   ARB_RR_EN  undefined -> fixed priority, D always wins ties
//
// Every output is a flop. No input has a combinational path to an output.

module umem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int LINE_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  // instruction side
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  // data side
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_done,
  // returned read line
  output logic [LINE_W-1:0] rd_line,
  // memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_rdy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Next-state values of the registered outputs.
  logic [ADDR_W-1:0] mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_d;
  logic              mem_re_d;
  logic              mem_we_d;
  logic [LINE_W-1:0] rd_line_d;
  logic              i_done_d;
  logic              d_done_d;

  // Grant decision. It only matters while the state is IDLE.
  logic grant_i;
  logic grant_d;

`ifdef ARB_RR_EN
  // Last-served pointer: 0 = I was served last, 1 = D was served last.
  logic last_d_q;

  // Round-robin tie-break: on a tie, the side that was not served last wins.
  always_comb begin
    grant_d = d_req & (~i_req | ~last_d_q);
    grant_i = i_req & ~grant_d;
  end

  // Update the pointer on every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d_q <= 1'b0;
    end else if (state_q == IDLE && (grant_i || grant_d)) begin
      last_d_q <= grant_d;
    end
  end
`else
  // Fixed priority: D wins every tie, so I can starve while d_req stays high.
  always_comb begin
    grant_d = d_req;
    grant_i = i_req & ~d_req;
  end
`endif

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    // NOTE: every signal gets a default here before the case statement. A
    // branch that forgets one then holds the flop instead of inferring a latch.
    state_d     = state_q;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_re_d    = mem_re;
    mem_we_d    = mem_we;
    rd_line_d   = rd_line;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // Requests are sampled only here. The granted operation is latched
        // into the memory-side registers, so later input churn has no effect.
        if (grant_d) begin
          state_d     = BUSY_D;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_we_d    = d_we;
          mem_re_d    = ~d_we;
        end else if (grant_i) begin
          state_d    = BUSY_I;
          mem_addr_d = i_addr;
          mem_re_d   = 1'b1;
          mem_we_d   = 1'b0;
        end
      end

      BUSY_I: begin
        // Hold the read strobe until the memory completes.
        if (mem_rdy) begin
          state_d   = RESP;
          rd_line_d = mem_rdata;
          mem_re_d  = 1'b0;
          mem_we_d  = 1'b0;
          i_done_d  = 1'b1;
        end
      end

      BUSY_D: begin
        // A write-back leaves rd_line untouched. Only a fill captures data.
        if (mem_rdy) begin
          state_d = RESP;
          if (mem_re) begin
            rd_line_d = mem_rdata;
          end
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
          d_done_d = 1'b1;
        end
      end

      RESP: begin
        // The done pulse is visible this cycle. mem_rdy is ignored here.
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        mem_re_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers (address, write data, read line) are
      // reset as well. Their reset values are visible on the ports, and an
      // abandoned fill must not leave a half-captured line behind.
      state_q   <= IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      rd_line   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge values no matter what order they appear in.
      state_q   <= state_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_re    <= mem_re_d;
      mem_we    <= mem_we_d;
      rd_line   <= rd_line_d;
      i_done    <= i_done_d;
      d_done    <= d_done_d;
    end
  end

  // Structural invariants of the sequencer.
  a_strobe_excl : assert property (@(posedge clk) disable iff (rst)
    !(mem_re && mem_we));
  a_done_excl   : assert property (@(posedge clk) disable iff (rst)
    !(i_done && d_done));
  a_done_resp   : assert property (@(posedge clk) disable iff (rst)
    (i_done || d_done) |-> (state_q == RESP));
  a_resp_quiet  : assert property (@(posedge clk) disable iff (rst)
    (state_q == RESP) |-> (!mem_re && !mem_we));

endmodule
